shift_reg_sequencer: RTL and testbench

//  Sequences one right_left_shift_reg instance through a full-duplex serial transfer:

---
 rtl/shift_reg_sequencer_if.sv | 28 ++
 rtl/shift_reg_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_reg_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_sequencer_if.sv
// Request-side bus of the shift-register sequencer: word/direction handshake,
// serial input, flow control and the transfer result.
interface shift_reg_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             ready;
   logic             dir;
   logic [WIDTH-1:0] tx_word;
   logic             serial_in;
   logic             stall;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rx_word;

   // Handshake: a transfer is accepted on a rising clock edge where start=1 and
   // ready=1; dir/tx_word are sampled on that edge. start while ready=0 is dropped.
   modport master (
      output start, dir, tx_word, serial_in, stall, abort,
      input  ready, busy, done, rx_word
   );

   modport slave (
      input  start, dir, tx_word, serial_in, stall, abort,
      output ready, busy, done, rx_word
   );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Drives one right/left shift register through load, WIDTH shifts and capture,
// returning the shifted-in word to the requester with a one-cycle done pulse.
module shift_reg_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   shift_reg_sequencer_if.slave bus,
   output logic                 sr_en,
   output logic                 sr_pl,
   output logic                 sr_right_left,
   output logic                 sr_new_bit,
   output logic [WIDTH-1:0]     sr_din,
   input  logic [WIDTH-1:0]     sr_bits,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             dir_q;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] rx_q;
   logic             ready_q;
   logic             busy_q;
   logic             pl_q;
   logic             shift_q;
   logic             done_q;
   logic             done_w;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         dir_q   <= 1'b0;
         word_q  <= '0;
         rx_q    <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         pl_q    <= 1'b0;
         shift_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.abort && state != IDLE) begin
         // Cancel wins over stall and start; the result register is left untouched.
         state   <= IDLE;
         count   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         pl_q    <= 1'b0;
         shift_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dir_q   <= bus.dir;
                  word_q  <= bus.tx_word;
                  state   <= LOAD;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  pl_q    <= 1'b1;
               end
            end
            LOAD: begin
               count   <= '0;
               state   <= SHIFT;
               pl_q    <= 1'b0;
               shift_q <= 1'b1;
            end
            SHIFT: begin
               if (!bus.stall) begin
                  if (count == LAST) begin
                     state   <= DONE;
                     shift_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            DONE: begin
               rx_q    <= sr_bits;
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               pl_q    <= 1'b0;
               shift_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // In the DONE cycle the register already holds the final word, so it is
   // presented directly while done is high and held from rx_q afterwards.
   assign done_w        = done_q & ~bus.abort;
   assign bus.done      = done_w;
   assign bus.rx_word   = done_w ? sr_bits : rx_q;
   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;

   assign sr_en         = shift_q & ~bus.stall;
   assign sr_pl         = pl_q;
   assign sr_right_left = busy_q & dir_q;
   assign sr_din        = busy_q ? word_q : '0;
   assign sr_new_bit    = bus.serial_in;
   assign dbg_state     = state;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural shift register in
// the loop; each scenario task drives its vectors and checks hand-computed results.
module tb_shift_reg_sequencer;

   localparam int W = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         sr_en, sr_pl, sr_right_left, sr_new_bit;
   logic [W-1:0] sr_din;
   logic [W-1:0] reg_bits = '0;
   logic [1:0]   dbg_state;
   logic         d_out;

   int checks = 0;
   int errors = 0;

   logic         pl_log[0:31];
   logic         en_log[0:31];
   logic         done_log[0:31];
   logic         ready_log[0:31];
   logic         busy_log[0:31];
   logic         dout_log[0:31];
   logic [W-1:0] rx_log[0:31];
   logic [1:0]   st_log[0:31];

   shift_reg_sequencer_if #(.WIDTH(W)) bus ();

   shift_reg_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus.slave),
      .sr_en         (sr_en),
      .sr_pl         (sr_pl),
      .sr_right_left (sr_right_left),
      .sr_new_bit    (sr_new_bit),
      .sr_din        (sr_din),
      .sr_bits       (reg_bits),
      .dbg_state     (dbg_state)
   );

   always #5 clock = ~clock;

   // Shift register the sequencer controls: load has priority over shift.
   always @(posedge clock) begin
      if (sr_pl)
         reg_bits <= sr_din;
      else if (sr_en)
         reg_bits <= sr_right_left ? {reg_bits[W-2:0], sr_new_bit}
                                   : {sr_new_bit, reg_bits[W-1:1]};
   end
   assign d_out = sr_right_left ? reg_bits[W-1] : reg_bits[0];

   initial begin
      bus.start     = 1'b0;
      bus.dir       = 1'b0;
      bus.tx_word   = '0;
      bus.serial_in = 1'b0;
      bus.stall     = 1'b0;
      bus.abort     = 1'b0;
   end

   // Cycle 0 is the cycle in which start is presented to an idle DUT.
   task automatic run_xfer(input logic d, input logic [W-1:0] tx, input logic si,
                           input int ncyc, input int stall_lo, input int stall_hi,
                           input int abort_c, input bit hold);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clock); #1;
         bus.start     = (c == 0) || hold;
         bus.dir       = d;
         bus.tx_word   = tx;
         bus.serial_in = si;
         bus.stall     = (c >= stall_lo) && (c <= stall_hi);
         bus.abort     = (c == abort_c);
         @(negedge clock);
         pl_log[c]    = sr_pl;
         en_log[c]    = sr_en;
         done_log[c]  = bus.done;
         ready_log[c] = bus.ready;
         busy_log[c]  = bus.busy;
         dout_log[c]  = d_out;
         rx_log[c]    = bus.rx_word;
         st_log[c]    = dbg_state;
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clock);
         if (bus.ready) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", bus.ready, budget);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         bus.start = ~bus.start;
         @(negedge clock);
         checks++;
         if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status: ready/busy/done=%b required 100", {bus.ready, bus.busy, bus.done});
         end
         checks++;
         if ({sr_en, sr_pl, sr_right_left, sr_din} !== 7'b0) begin
            errors++;
            $display("FAIL reset_sr: en/pl/rl/din=%b required 0000000", {sr_en, sr_pl, sr_right_left, sr_din});
         end
         checks++;
         if (bus.rx_word !== 4'b0000 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_rx_state: rx_word=%b state=%0d required 0000/0", bus.rx_word, dbg_state);
         end
      end
      bus.start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_right_shift;
      int en_n = 0; int first_en = -1; int done_c = -1;
      logic [W-1:0] seq = '0;
      run_xfer(1'b0, 4'b1011, 1'b1, 8, 99, -1, 99, 1'b0);
      for (int c = 0; c < 8; c++) begin
         if (en_log[c]) begin
            en_n++;
            if (first_en < 0) first_en = c;
            seq = {seq[W-2:0], dout_log[c]};
         end
         if (done_log[c]) done_c = c;
      end
      checks++;
      if (pl_log[1] !== 1'b1 || pl_log[2] !== 1'b0 || st_log[1] !== 2'd1) begin
         errors++;
         $display("FAIL right_load: pl[1]=%b pl[2]=%b state[1]=%0d required 1/0/1", pl_log[1], pl_log[2], st_log[1]);
      end
      checks++;
      if (en_n != 4 || first_en != 2) begin
         errors++;
         $display("FAIL right_en: count=%0d first=%0d required 4/2", en_n, first_en);
      end
      checks++;
      if (done_c != 6) begin
         errors++;
         $display("FAIL right_done_cycle: got %0d required 6", done_c);
      end
      checks++;
      if (rx_log[6] !== 4'b1111 || rx_log[7] !== 4'b1111) begin
         errors++;
         $display("FAIL right_rx: at done %b after %b required 1111", rx_log[6], rx_log[7]);
      end
      checks++;
      if (seq !== 4'b1101) begin
         errors++;
         $display("FAIL right_dout: sequence %b required 1101", seq);
      end
      checks++;
      if (ready_log[7] !== 1'b1 || busy_log[6] !== 1'b1 || ready_log[6] !== 1'b0) begin
         errors++;
         $display("FAIL right_ready: ready[6]=%b busy[6]=%b ready[7]=%b required 0/1/1", ready_log[6], busy_log[6], ready_log[7]);
      end
   endtask

   task automatic test_left_shift;
      int done_c = -1;
      logic [W-1:0] seq = '1;
      run_xfer(1'b1, 4'b0001, 1'b0, 8, 99, -1, 99, 1'b0);
      for (int c = 0; c < 8; c++) begin
         if (en_log[c]) seq = {seq[W-2:0], dout_log[c]};
         if (done_log[c]) done_c = c;
      end
      checks++;
      if (seq !== 4'b0001) begin
         errors++;
         $display("FAIL left_dout: sequence %b required 0001", seq);
      end
      checks++;
      if (done_c != 6 || rx_log[6] !== 4'b0000 || rx_log[7] !== 4'b0000) begin
         errors++;
         $display("FAIL left_rx: done at %0d rx %b/%b required 6 and 0000", done_c, rx_log[6], rx_log[7]);
      end
   endtask

   task automatic test_stall;
      int en_n = 0; int done_c = -1;
      logic [W-1:0] seq = '0;
      run_xfer(1'b0, 4'b1011, 1'b1, 11, 4, 6, 99, 1'b0);
      for (int c = 0; c < 11; c++) begin
         if (en_log[c]) begin
            en_n++;
            seq = {seq[W-2:0], dout_log[c]};
         end
         if (done_log[c]) done_c = c;
      end
      checks++;
      if (en_n != 4 || en_log[5] !== 1'b0 || en_log[7] !== 1'b1) begin
         errors++;
         $display("FAIL stall_en: count=%0d en[5]=%b en[7]=%b required 4/0/1", en_n, en_log[5], en_log[7]);
      end
      checks++;
      if (done_c != 9 || rx_log[9] !== 4'b1111 || seq !== 4'b1101) begin
         errors++;
         $display("FAIL stall_done: done at %0d rx %b dout %b required 9/1111/1101", done_c, rx_log[9], seq);
      end
   endtask

   task automatic test_abort;
      int done_n = 0; int en_after = 0; int rx_bad = 0;
      run_xfer(1'b0, 4'b0000, 1'b0, 10, 99, -1, 4, 1'b0);
      for (int c = 0; c < 10; c++) begin
         if (done_log[c]) done_n++;
         if (c >= 5 && (en_log[c] || pl_log[c])) en_after++;
         if (rx_log[c] !== 4'b1111) rx_bad++;
      end
      checks++;
      if (done_n != 0 || en_after != 0) begin
         errors++;
         $display("FAIL abort_quiet: done pulses %0d sr activity after abort %0d required 0/0", done_n, en_after);
      end
      checks++;
      if (rx_bad != 0) begin
         errors++;
         $display("FAIL abort_rx: %0d cycles rx_word differed, required 0 (hold 1111)", rx_bad);
      end
      checks++;
      if (ready_log[5] !== 1'b1 || busy_log[5] !== 1'b0 || busy_log[4] !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle: busy[4]=%b ready[5]=%b busy[5]=%b required 1/1/0", busy_log[4], ready_log[5], busy_log[5]);
      end
   endtask

   task automatic test_back_to_back;
      int pl_n = 0; int busy_ready = 0;
      run_xfer(1'b0, 4'b0101, 1'b1, 10, 99, -1, 99, 1'b1);
      for (int c = 0; c < 10; c++) begin
         if (pl_log[c]) pl_n++;
         if (c >= 1 && c <= 6 && ready_log[c]) busy_ready++;
      end
      checks++;
      if (pl_n != 2 || pl_log[1] !== 1'b1 || pl_log[8] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_loads: count=%0d pl[1]=%b pl[8]=%b required 2/1/1", pl_n, pl_log[1], pl_log[8]);
      end
      checks++;
      if (busy_ready != 0 || ready_log[7] !== 1'b1 || done_log[6] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready: early ready %0d ready[7]=%b done[6]=%b required 0/1/1", busy_ready, ready_log[7], done_log[6]);
      end
      wait_ready(30);
   endtask

   task automatic test_reset_mid;
      int done_n = 0;
      @(posedge clock); #1;
      bus.start = 1'b1; bus.dir = 1'b0; bus.tx_word = 4'b1011; bus.serial_in = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || sr_en !== 1'b0 || sr_pl !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b ready=%b en=%b pl=%b required 0/1/0/0", bus.busy, bus.ready, sr_en, sr_pl);
      end
      checks++;
      if (bus.rx_word !== 4'b0000 || dbg_state !== 2'd0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_rx: rx=%b state=%0d done=%b required 0000/0/0", bus.rx_word, dbg_state, bus.done);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.done) done_n++;
      end
      checks++;
      if (done_n != 0) begin
         errors++;
         $display("FAIL reset_mid_done: %0d done pulses required 0", done_n);
      end
   endtask

   initial begin
      test_reset();
      test_right_shift();
      test_left_shift();
      test_stall();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
